// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Bundles the IRAM read port, the instruction valid/ready handshake,
//   the jump redirect request and the fetch status outputs of instr_fetch.
//   master : the fetch unit's view (drives IRAM address/strobe, instr, status)
//   slave  : the surrounding view (IRAM data, control-unit ready/redirect)
// Parameters: ADDR_W (PC / IRAM address width), INSTR_W (instruction width),
//   CNT_W (delivered-instruction counter width, 16 in the standard build).
interface instr_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20,
  parameter int CNT_W   = 16
);
  logic               iram_rd_en;
  logic [ADDR_W-1:0]  iram_addr;
  logic [INSTR_W-1:0] iram_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect;
  logic [5:0]         redirect_tgt;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic [CNT_W-1:0]   fetch_cnt;

  modport master (
    output iram_rd_en, iram_addr, instr, instr_valid, pc, halted, fetch_cnt,
    input  iram_rdata, instr_ready, redirect, redirect_tgt
  );

  modport slave (
    input  iram_rd_en, iram_addr, instr, instr_valid, pc, halted, fetch_cnt,
    output iram_rdata, instr_ready, redirect, redirect_tgt
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
//   Instruction fetch unit. Owns the program counter, reads IRAM through a
//   synchronous one-cycle-latency port and offers one instruction at a time
//   to the control FSM under valid/ready. Jump redirects from control take
//   priority over every other transition. A HALT opcode (4'b1111) parks the
//   unit until a redirect or reset.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_if.master (IRAM read port, instr/instr_valid/
//           instr_ready handshake, redirect/redirect_tgt, pc, halted,
//           fetch_cnt)
module instr_fetch #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {REQ, WAIT, VALID, HALTED} state_t;

  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc_q, pc_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_valid_q;
  logic               halted_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               load_instr;
  logic               accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A handshake completes whenever the held instruction is offered and taken,
  // even if a redirect arrives in the same cycle.
  assign accept = (state == VALID) && bus.instr_ready;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    load_instr = 1'b0;
    if (bus.redirect) begin
      // Redirect wins: any data returning from an in-flight read is dropped.
      state_nxt = REQ;
      pc_nxt    = ADDR_W'(bus.redirect_tgt);
    end else begin
      case (state)
        REQ:    state_nxt = WAIT;
        WAIT: begin
          load_instr = 1'b1;
          state_nxt  = (bus.iram_rdata[INSTR_W-1 -: 4] == OP_HALT) ? HALTED : VALID;
        end
        VALID: begin
          if (bus.instr_ready) begin
            pc_nxt    = pc_q + ADDR_W'(1);
            state_nxt = REQ;
          end
        end
        HALTED: state_nxt = HALTED;
        default: state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= REQ;
    else        state <= state_nxt;
  end

  // Registered outputs are computed from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pc_q          <= pc_nxt;
      if (load_instr) instr_q <= bus.iram_rdata;
      instr_valid_q <= (state_nxt == VALID);
      halted_q      <= (state_nxt == HALTED);
      if (accept) cnt_q <= sat_inc(cnt_q);
    end
  end

  // The read strobe is gated by rst_n so the IRAM sees no read while the
  // unit is held in reset; the first read goes out as soon as reset lifts.
  assign bus.iram_rd_en  = rst_n && (state == REQ);
  assign bus.iram_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sat_rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [INSTR_W-1:0] mem [256];

  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(16)) bus ();
  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(4))  sat_bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(4)) sat_dut (
    .clk(clk), .rst_n(sat_rst_n), .bus(sat_bus));

  always #5 clk = ~clk;

  // Synchronous IRAM with one cycle of read latency.
  always @(posedge clk) if (bus.iram_rd_en) bus.iram_rdata <= mem[bus.iram_addr];

  // Narrow-counter instance: constant non-halt instruction, always ready.
  assign sat_bus.iram_rdata   = 20'h1_0000;
  assign sat_bus.instr_ready  = 1'b1;
  assign sat_bus.redirect     = 1'b0;
  assign sat_bus.redirect_tgt = 6'h00;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    bus.instr_ready  = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_tgt = 6'h00;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < 256; i++)
      mem[i] = {4'($urandom_range(0, 14)), 16'($urandom)};
  endtask

  task automatic test_reset();
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_tgt = 6'h00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.instr !== 20'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    n_checks++; if (bus.fetch_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", bus.fetch_cnt); end
    n_checks++; if (bus.pc !== 8'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.pc); end
    n_checks++; if (bus.iram_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.iram_rd_en); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++; if (bus.iram_rd_en !== 1'b1) begin n_fail++; $display("FAIL release_rd_en: got %b want 1", bus.iram_rd_en); end
    n_checks++; if (bus.iram_addr !== 8'h0) begin n_fail++; $display("FAIL release_addr: got %h want 0", bus.iram_addr); end
  endtask

  task automatic test_fetch_sequence();
    mem[0] = 20'h2_1000; mem[1] = 20'h8_1200; mem[2] = 20'h5_3400; mem[3] = 20'h1_2345;
    apply_reset();
    bus.instr_ready = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      n_checks++;
      if (bus.instr_valid !== 1'((n % 3) == 0)) begin
        n_fail++; $display("FAIL seq_valid cycle %0d: got %b want %b", n, bus.instr_valid, (n % 3) == 0);
      end
      if ((n % 3) == 0) begin
        n_checks++; if (bus.instr !== mem[n/3-1]) begin n_fail++; $display("FAIL seq_instr cycle %0d: got %h want %h", n, bus.instr, mem[n/3-1]); end
        n_checks++; if (bus.pc !== 8'(n/3-1)) begin n_fail++; $display("FAIL seq_pc cycle %0d: got %h want %h", n, bus.pc, 8'(n/3-1)); end
      end
    end
    @(negedge clk);
    n_checks++; if (bus.fetch_cnt !== 16'd3) begin n_fail++; $display("FAIL seq_cnt: got %0d want 3", bus.fetch_cnt); end
    n_checks++; if (bus.iram_addr !== 8'd3 || bus.iram_rd_en !== 1'b1) begin n_fail++; $display("FAIL seq_next_req: got en=%b addr=%h want en=1 addr=03", bus.iram_rd_en, bus.iram_addr); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    mem[0] = 20'h3_0AB0; mem[1] = 20'h4_0CD0;
    apply_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid hold %0d: got %b want 1", i, bus.instr_valid); end
      n_checks++; if (bus.instr !== mem[0]) begin n_fail++; $display("FAIL bp_instr hold %0d: got %h want %h", i, bus.instr, mem[0]); end
      n_checks++; if (bus.pc !== 8'h0) begin n_fail++; $display("FAIL bp_pc hold %0d: got %h want 0", i, bus.pc); end
      n_checks++; if (bus.iram_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en hold %0d: got %b want 0", i, bus.iram_rd_en); end
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.iram_rd_en !== 1'b1 || bus.iram_addr !== 8'h1) begin n_fail++; $display("FAIL bp_release_req: got en=%b addr=%h want en=1 addr=01", bus.iram_rd_en, bus.iram_addr); end
    n_checks++; if (bus.fetch_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_cnt: got %0d want 1", bus.fetch_cnt); end
  endtask

  task automatic test_redirect();
    mem[0] = 20'h6_1111; mem[8'h2A] = 20'h7_2A2A; mem[8'h2B] = 20'h7_2B2B;
    apply_reset();
    repeat (2) @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_tgt = 6'h2A;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++; if (bus.instr !== 20'h0) begin n_fail++; $display("FAIL rd_wait_discard: got %h want 00000", bus.instr); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_wait_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.iram_rd_en !== 1'b1 || bus.iram_addr !== 8'h2A) begin n_fail++; $display("FAIL rd_wait_req: got en=%b addr=%h want en=1 addr=2a", bus.iram_rd_en, bus.iram_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== mem[8'h2A]) begin n_fail++; $display("FAIL rd_target: got v=%b %h want v=1 %h", bus.instr_valid, bus.instr, mem[8'h2A]); end
    n_checks++; if (bus.pc !== 8'h2A) begin n_fail++; $display("FAIL rd_target_pc: got %h want 2a", bus.pc); end
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_tgt = 6'h2A;
    @(negedge clk);
    bus.instr_ready = 1'b0; bus.redirect = 1'b0;
    n_checks++; if (bus.pc !== 8'h2A) begin n_fail++; $display("FAIL rd_accept_pc: got %h want 2a", bus.pc); end
    n_checks++; if (bus.fetch_cnt !== 16'd1) begin n_fail++; $display("FAIL rd_accept_cnt: got %0d want 1", bus.fetch_cnt); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_accept_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.iram_addr !== 8'h2A) begin n_fail++; $display("FAIL rd_accept_addr: got %h want 2a", bus.iram_addr); end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 4; i++) mem[i] = 20'h1_0000 + 20'(i);
    mem[4] = 20'hF_0000;
    apply_reset();
    bus.instr_ready = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n % 3 == 0 && n <= 12) begin
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== mem[n/3-1]) begin n_fail++; $display("FAIL halt_pre cycle %0d: got v=%b %h want v=1 %h", n, bus.instr_valid, bus.instr, mem[n/3-1]); end
      end
      if (n == 13) begin
        n_checks++; if (bus.iram_rd_en !== 1'b1 || bus.iram_addr !== 8'h4) begin n_fail++; $display("FAIL halt_req: got en=%b addr=%h want en=1 addr=04", bus.iram_rd_en, bus.iram_addr); end
      end
    end
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", bus.halted); end
    n_checks++; if (bus.instr !== 20'hF_0000) begin n_fail++; $display("FAIL halt_instr: got %h want f0000", bus.instr); end
    n_checks++; if (bus.pc !== 8'h4) begin n_fail++; $display("FAIL halt_pc: got %h want 04", bus.pc); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.iram_rd_en !== 1'b0) begin n_fail++; $display("FAIL halt_hold %0d: got h=%b v=%b en=%b want h=1 v=0 en=0", i, bus.halted, bus.instr_valid, bus.iram_rd_en); end
      n_checks++; if (bus.fetch_cnt !== 16'd4) begin n_fail++; $display("FAIL halt_cnt %0d: got %0d want 4", i, bus.fetch_cnt); end
      if (i < 3) @(negedge clk);
    end
    bus.redirect = 1'b1; bus.redirect_tgt = 6'h00;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b want 0", bus.halted); end
    n_checks++; if (bus.iram_rd_en !== 1'b1 || bus.iram_addr !== 8'h0) begin n_fail++; $display("FAIL halt_restart_req: got en=%b addr=%h want en=1 addr=00", bus.iram_rd_en, bus.iram_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== mem[0]) begin n_fail++; $display("FAIL halt_restart_instr: got v=%b %h want v=1 %h", bus.instr_valid, bus.instr, mem[0]); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    fill_mem_random();
    apply_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 258; i++) begin
      int w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (bus.instr_valid !== 1'b1 && w < 4);
      n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout delivery %0d: got valid=%b want 1 within 3 cycles", i, bus.instr_valid); end
      n_checks++; if (bus.pc !== 8'(i) || bus.instr !== mem[i % 256]) begin n_fail++; $display("FAIL wrap_delivery %0d: got pc=%h %h want pc=%h %h", i, bus.pc, bus.instr, 8'(i), mem[i % 256]); end
    end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    n_checks++; if (bus.fetch_cnt !== 16'd258) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 258", bus.fetch_cnt); end
  endtask

  // Reference: after each accept or redirect the unit spends one cycle
  // reading, one waiting, then offers mem[target] until taken or redirected.
  task automatic test_random();
    int          k = 1;
    logic [7:0]  mpc = 8'h0;
    logic [15:0] mcnt = 16'h0;
    logic        exp_valid, rdy, rdr, acc;
    logic [5:0]  tgt;
    fill_mem_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      exp_valid = (k >= 3);
      n_checks++; if (bus.instr_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b want %b", c, bus.instr_valid, exp_valid); end
      n_checks++; if (bus.iram_rd_en !== 1'(k == 1)) begin n_fail++; $display("FAIL rnd_rd_en cyc %0d: got %b want %b", c, bus.iram_rd_en, k == 1); end
      n_checks++; if (bus.pc !== mpc) begin n_fail++; $display("FAIL rnd_pc cyc %0d: got %h want %h", c, bus.pc, mpc); end
      n_checks++; if (bus.fetch_cnt !== mcnt) begin n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", c, bus.fetch_cnt, mcnt); end
      n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rnd_halted cyc %0d: got %b want 0", c, bus.halted); end
      if (k == 1) begin
        n_checks++; if (bus.iram_addr !== mpc) begin n_fail++; $display("FAIL rnd_addr cyc %0d: got %h want %h", c, bus.iram_addr, mpc); end
      end
      if (exp_valid) begin
        n_checks++; if (bus.instr !== mem[mpc]) begin n_fail++; $display("FAIL rnd_instr cyc %0d: got %h want %h", c, bus.instr, mem[mpc]); end
      end
      rdy = 1'($urandom_range(0, 1));
      rdr = ($urandom_range(0, 7) == 0);
      tgt = 6'($urandom);
      bus.instr_ready = rdy; bus.redirect = rdr; bus.redirect_tgt = tgt;
      acc = exp_valid && rdy;
      if (acc) mcnt = mcnt + 16'd1;
      if (rdr) begin
        mpc = {2'b00, tgt}; k = 1;
      end else if (acc) begin
        mpc = mpc + 8'd1; k = 1;
      end else begin
        k++;
      end
    end
    @(negedge clk);
    bus.instr_ready = 1'b0; bus.redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    mem[0] = 20'h9_0001; mem[1] = 20'h9_0002;
    apply_reset();
    bus.instr_ready = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    bus.instr_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_tgt = 6'h2A;
    #1;
    n_checks++; if (bus.instr !== 20'h0 || bus.instr_valid !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL areset_out: got %h v=%b h=%b want 00000 v=0 h=0", bus.instr, bus.instr_valid, bus.halted); end
    n_checks++; if (bus.pc !== 8'h0 || bus.fetch_cnt !== 16'h0) begin n_fail++; $display("FAIL areset_state: got pc=%h cnt=%0d want pc=00 cnt=0", bus.pc, bus.fetch_cnt); end
    n_checks++; if (bus.iram_rd_en !== 1'b0 || bus.iram_addr !== 8'h0) begin n_fail++; $display("FAIL areset_iram: got en=%b addr=%h want en=0 addr=00", bus.iram_rd_en, bus.iram_addr); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.pc !== 8'h0) begin n_fail++; $display("FAIL areset_vs_redirect: got pc=%h want 00", bus.pc); end
    bus.redirect = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.iram_rd_en !== 1'b1 || bus.iram_addr !== 8'h0) begin n_fail++; $display("FAIL areset_restart: got en=%b addr=%h want en=1 addr=00", bus.iram_rd_en, bus.iram_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== mem[0]) begin n_fail++; $display("FAIL areset_first: got v=%b %h want v=1 %h", bus.instr_valid, bus.instr, mem[0]); end
  endtask

  task automatic test_saturation();
    int acc = 0;
    @(negedge clk);
    sat_rst_n = 1'b0;
    @(posedge clk);
    #1 sat_rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_checks++; if (sat_bus.fetch_cnt !== 4'((acc > 15) ? 15 : acc)) begin n_fail++; $display("FAIL sat_cnt cyc %0d: got %0d want %0d", c, sat_bus.fetch_cnt, (acc > 15) ? 15 : acc); end
      if (sat_bus.iram_rd_en) begin
        n_checks++; if (sat_bus.iram_addr !== 8'(acc)) begin n_fail++; $display("FAIL sat_addr cyc %0d: got %h want %h", c, sat_bus.iram_addr, 8'(acc)); end
      end
      if (sat_bus.instr_valid) begin
        n_checks++; if (sat_bus.instr !== 20'h1_0000 || sat_bus.pc !== 8'(acc) || sat_bus.halted !== 1'b0) begin n_fail++; $display("FAIL sat_deliver cyc %0d: got %h pc=%h h=%b want 10000 pc=%h h=0", c, sat_bus.instr, sat_bus.pc, sat_bus.halted, 8'(acc)); end
        acc++;
      end
    end
    @(negedge clk);
    n_checks++; if (acc < 16 || sat_bus.fetch_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_final: got cnt=%0d after %0d accepts want 15", sat_bus.fetch_cnt, acc); end
  endtask

  initial begin
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_tgt = 6'h00;
    test_reset();
    test_fetch_sequence();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_random();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that supplies 20-bit instructions to the control FSM. It owns the program counter and reads instruction RAM over a synchronous one-cycle-latency port. It presents one instruction at a time under a valid/ready handshake and applies jump redirects issued by the control FSM. It sits between IRAM and the control unit, replacing the control unit's implicit fetch1/fetch2 sequencing with an explicit producer.

## Interface
Parameters:
- ADDR_W, 8, IRAM address / PC width (must be ≥ 6)
- INSTR_W, 20, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- iram_rd_en  out  1  IRAM read strobe
- iram_addr  out  ADDR_W  IRAM read address
- iram_rdata  in  INSTR_W  IRAM data, valid the cycle after iram_rd_en
- instr  out  INSTR_W  current instruction (held register)
- instr_valid  out  1  instr is valid for the control FSM
- instr_ready  in  1  control FSM accepts instr this cycle
- redirect  in  1  jump request from control (jmp, or jmpz with z==0)
- redirect_tgt  in  6  jump target (control's alpha), zero-extended to ADDR_W
- pc  out  ADDR_W  address of instr currently held or being fetched
- halted  out  1  HALT opcode reached
- fetch_cnt  out  16  count of instructions delivered, saturating

## Operation
- States: REQ, WAIT, VALID, HALTED.
- REQ: iram_rd_en=1, iram_addr=pc; next WAIT.
- WAIT: iram_rdata is captured into instr at the end of this cycle.
  - Opcode 4'b1111 → HALTED. instr is still loaded; instr_valid stays 0.
  - Otherwise → VALID.
- VALID: instr_valid=1. On instr_ready=1: pc ← pc+1 (mod 2^ADDR_W), fetch_cnt ← fetch_cnt+1 (saturates at 16'hFFFF), next REQ. instr holds its value until the next capture.
- HALTED: halted=1, instr_valid=0, no IRAM reads. Exited only by reset or redirect.
- Redirect, any state, has priority over every other transition:
  - pc ← {0, redirect_tgt}; next REQ; instr_valid drops the following cycle.
  - In WAIT: the returning iram_rdata is discarded and instr is not updated.
  - In VALID with instr_ready=1 in the same cycle: the handshake completes and fetch_cnt increments, but pc takes the target, not pc+1.
  - In HALTED: halted clears the next cycle.
- Outputs are registered, except iram_rd_en and iram_addr, which are decoded from state and pc.
- Reset (asynchronous, any state, including mid-fetch): state=REQ, pc=0, instr=0, instr_valid=0, halted=0, fetch_cnt=0. iram_rd_en=1 and iram_addr=0 once rst_n deasserts.

## Timing
- Fetch latency, REQ to instr_valid: 2 cycles (REQ, WAIT, then VALID in the 3rd cycle).
- With instr_ready tied high, throughput is 1 instruction per 3 cycles.
- Handshake:
  - instr_valid, once high, stays high and instr stays stable until instr_ready or redirect.
  - instr_ready while instr_valid=0 is ignored.
- Redirect to first target read: the cycle after redirect is REQ with iram_addr = target. The target instruction is valid 3 cycles after the redirect cycle.
- PC wrap: pc = 2^ADDR_W-1 accepted → pc = 0 with no halt or error.
- Redirect and rst_n low together: reset wins.

## Test plan
- Reset release with IRAM[0..2] = 20'h2_1000, 20'h8_1200, 20'h5_3400 and ready high → instr_valid at cycles 3, 6, 9 with those values; pc 0, 1, 2; fetch_cnt reaches 3.
- Backpressure: hold instr_ready low 5 cycles in VALID → instr, pc and instr_valid stable; no iram_rd_en pulses; release → next REQ the cycle after acceptance.
- Redirect:
  - With target 6'h2A asserted in WAIT → old rdata discarded; next iram_addr = 8'h2A.
  - Asserted simultaneously with ready in VALID → pc = 8'h2A, not pc+1.
- Halt: IRAM[4] = 20'hF_0000 → halted=1 after WAIT, instr_valid stays 0, no further reads. Redirect to 6'h00 → halted=0 and fetch restarts at 0.
- Wrap and saturation:
  - pc = 8'hFF accepted → pc = 8'h00.
  - Force 65540 accepts → fetch_cnt = 16'hFFFF.
- Asynchronous reset asserted mid-WAIT → all outputs zero immediately; fetch restarts at address 0 after release.
